sum_collector: RTL and testbench

- Downstream stage of the registered 3-bit adder.
- Consumes the adder's sum stream one beat per accepted cycle and accumulates N beats into a wider total.
- Presents the total with group beat count and overflow flag on a valid/ready output.
- Back-pressures the upstream while a total is pending; a flush input emits a partial group early.

---
 rtl/sum_collector_if.sv | 26 ++
 rtl/sum_collector.sv | 79 +++++++
 tb/tb_sum_collector.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sum_collector_if.sv
// Handshake bundle between the adder stage, the sum collector and its consumer.
interface sum_collector_if #(
  parameter int DW = 3,
  parameter int AW = 5,
  parameter int CW = 3
);
  logic [DW-1:0] sum_in;
  logic          sum_valid;
  logic          sum_ready;
  logic          flush;
  logic [AW-1:0] total_out;
  logic [CW-1:0] count_out;
  logic          ovf_out;
  logic          total_valid;
  logic          total_ready;

  modport master (
    output sum_in, sum_valid, flush, total_ready,
    input  sum_ready, total_out, count_out, ovf_out, total_valid
  );

  modport slave (
    input  sum_in, sum_valid, flush, total_ready,
    output sum_ready, total_out, count_out, ovf_out, total_valid
  );
endinterface

// File: rtl/sum_collector.sv
// Accumulates N sum beats (or a flushed partial group) into one total with
// beat count and sticky overflow, held on a valid/ready output until taken.
module sum_collector #(
  parameter int DW = 3,
  parameter int N  = 4,
  parameter int AW = 5,
  parameter int CW = 3
) (
  input  logic            iclk,
  input  logic            irst,
  sum_collector_if.slave  bus
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          ovf_acc;
  logic          accept;
  logic [AW:0]   sum_ext;
  logic [AW:0]   nxt;
  logic [CW-1:0] emit_cnt;

  assign bus.sum_ready = (state == ACCUM) && !irst;
  assign accept        = bus.sum_valid && bus.sum_ready;
  assign sum_ext       = {{(AW + 1 - DW){1'b0}}, bus.sum_in};

  always_comb begin
    nxt      = {1'b0, acc};
    emit_cnt = cnt;
    if (accept) begin
      nxt      = {1'b0, acc} + sum_ext;
      emit_cnt = cnt + CW'(1);
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state           <= ACCUM;
      acc             <= '0;
      cnt             <= '0;
      ovf_acc         <= 1'b0;
      bus.total_out   <= '0;
      bus.count_out   <= '0;
      bus.ovf_out     <= 1'b0;
      bus.total_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          // A completing beat and a flush share one emit path; emit_cnt
          // already includes any beat taken this cycle.
          if ((accept && cnt == CW'(N - 1)) || (bus.flush && (cnt != '0 || accept))) begin
            bus.total_out   <= nxt[AW-1:0];
            bus.count_out   <= emit_cnt;
            bus.ovf_out     <= ovf_acc | nxt[AW];
            bus.total_valid <= 1'b1;
            acc             <= '0;
            cnt             <= '0;
            ovf_acc         <= 1'b0;
            state           <= HOLD;
          end else if (accept) begin
            acc     <= nxt[AW-1:0];
            cnt     <= emit_cnt;
            ovf_acc <= ovf_acc | nxt[AW];
          end
        end
        HOLD: begin
          if (bus.total_ready) begin
            bus.total_valid <= 1'b0;
            state           <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_collector.sv
// Randomised and directed bench for sum_collector: a default-width instance and
// a 3-bit-total instance share one stimulus stream and one scoreboard.
module tb_sum_collector;

  localparam int N = 4;

  logic iclk = 1'b0;
  logic irst = 1'b1;

  sum_collector_if #(.DW(3), .AW(5), .CW(3)) b ();
  sum_collector_if #(.DW(3), .AW(3), .CW(3)) bn ();

  assign bn.sum_in      = b.sum_in;
  assign bn.sum_valid   = b.sum_valid;
  assign bn.flush       = b.flush;
  assign bn.total_ready = b.total_ready;

  sum_collector #(.DW(3), .N(N), .AW(5), .CW(3)) dut   (.iclk(iclk), .irst(irst), .bus(b));
  sum_collector #(.DW(3), .N(N), .AW(3), .CW(3)) dut_n (.iclk(iclk), .irst(irst), .bus(bn));

  always #5 iclk = ~iclk;

  typedef struct {
    int total;
    int count;
  } exp_t;

  exp_t q[$];
  int   grp[$];
  bit   m_hold = 1'b0;
  exp_t last = '{0, 0};
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input exp_t e);
    chk("total_out",   int'(b.total_out),  e.total % 32);
    chk("count_out",   int'(b.count_out),  e.count);
    chk("ovf_out",     int'(b.ovf_out),    int'(e.total >= 32));
    chk("total_out_n", int'(bn.total_out), e.total % 8);
    chk("count_out_n", int'(bn.count_out), e.count);
    chk("ovf_out_n",   int'(bn.ovf_out),   int'(e.total >= 8));
  endtask

  task automatic check_zero();
    chk("rst_sum_ready",   int'(b.sum_ready),    0);
    chk("rst_total_valid", int'(b.total_valid),  0);
    chk("rst_total_out",   int'(b.total_out),    0);
    chk("rst_count_out",   int'(b.count_out),    0);
    chk("rst_ovf_out",     int'(b.ovf_out),      0);
    chk("rst_sum_ready_n", int'(bn.sum_ready),   0);
    chk("rst_valid_n",     int'(bn.total_valid), 0);
    chk("rst_total_out_n", int'(bn.total_out),   0);
  endtask

  // Reference model: collects accepted beats into a group and, when the group
  // fills or is flushed, pushes its plain arithmetic sum and size.
  always @(posedge iclk or posedge irst) begin
    if (irst) begin
      grp.delete();
      q.delete();
      m_hold = 1'b0;
    end else if (m_hold) begin
      if (b.total_ready) m_hold = 1'b0;
    end else begin
      if (b.sum_valid) grp.push_back(int'(b.sum_in));
      if (grp.size() == N || (b.flush && grp.size() > 0)) begin
        exp_t e;
        e.total = 0;
        foreach (grp[i]) e.total += grp[i];
        e.count = grp.size();
        q.push_back(e);
        grp.delete();
        m_hold = 1'b1;
      end
    end
  end

  // Monitor: compares the presented total against the scoreboard head.
  always @(negedge iclk) begin
    if (irst) begin
      last = '{0, 0};
      check_zero();
    end else begin
      chk("sum_ready",     int'(b.sum_ready),    int'(!m_hold));
      chk("sum_ready_n",   int'(bn.sum_ready),   int'(!m_hold));
      chk("total_valid",   int'(b.total_valid),  int'(m_hold));
      chk("total_valid_n", int'(bn.total_valid), int'(m_hold));
      if (b.total_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_total", 1, 0);
        end else begin
          cmp(q[0]);
          if (b.total_ready) begin
            last = q[0];
            void'(q.pop_front());
          end
        end
      end else begin
        cmp(last);
      end
    end
  end

  task automatic beat(input int v, input bit fl);
    int t = 0;
    b.sum_valid = 1'b1;
    b.sum_in    = 3'(v);
    b.flush     = fl;
    do begin
      @(negedge iclk);
      t++;
    end while (!b.sum_ready && t < 100);
    if (t >= 100) chk("beat_timeout", 1, 0);
    @(posedge iclk);
    #1;
    b.sum_valid = 1'b0;
    b.flush     = 1'b0;
  endtask

  task automatic do_flush();
    b.flush = 1'b1;
    @(posedge iclk);
    #1;
    b.flush = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    b.total_ready = 1'b1;
    while (m_hold && t < 100) begin
      @(posedge iclk);
      #1;
      t++;
    end
    if (t >= 100) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    b.sum_valid   = 1'b0;
    b.sum_in      = '0;
    b.flush       = 1'b0;
    b.total_ready = 1'b1;
    irst          = 1'b1;
    repeat (2) @(posedge iclk);
    #1 irst = 1'b0;

    // basic group
    for (int i = 1; i <= 4; i++) beat(i, 1'b0);
    wait_idle();

    // backpressure with a held beat
    b.total_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(7, 1'b0);
    fork
      begin
        repeat (6) @(posedge iclk);
        #1 b.total_ready = 1'b1;
      end
    join_none
    beat(3, 1'b0);
    for (int i = 0; i < 3; i++) beat(1, 1'b0);
    wait_idle();

    // flush with a same-cycle beat, then an empty flush
    beat(5, 1'b0);
    beat(6, 1'b0);
    beat(2, 1'b1);
    wait_idle();
    @(posedge iclk);
    #1;
    do_flush();
    repeat (3) @(posedge iclk);
    #1;

    // overflow on the narrow instance
    beat(7, 1'b0);
    beat(7, 1'b0);
    do_flush();
    wait_idle();
    for (int i = 0; i < 4; i++) beat(1, 1'b0);
    wait_idle();

    // async reset mid-group
    beat(1, 1'b0);
    beat(1, 1'b0);
    #3 irst = 1'b1;
    #1 check_zero();
    @(posedge iclk);
    #1 irst = 1'b0;
    for (int i = 0; i < 4; i++) beat(1, 1'b0);
    wait_idle();

    // async reset while holding a total
    b.total_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(2, 1'b0);
    @(posedge iclk);
    #2 irst = 1'b1;
    #1 check_zero();
    @(posedge iclk);
    #1 irst = 1'b0;
    b.total_ready = 1'b1;
    for (int i = 0; i < 4; i++) beat(1, 1'b0);
    wait_idle();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      b.sum_valid   = ($urandom_range(0, 3) != 0);
      b.sum_in      = 3'($urandom_range(0, 7));
      b.flush       = ($urandom_range(0, 7) == 0);
      b.total_ready = ($urandom_range(0, 2) != 0);
      @(posedge iclk);
      #1;
    end
    b.sum_valid = 1'b0;
    b.flush     = 1'b0;
    wait_idle();
    repeat (3) @(posedge iclk);
    #1;
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
